// File: rtl/fifo_frame_read.sv
// Frame reader: pulls min(len,WORDS) words from a sync FIFO into res; optional stall timeout via FIFO_READ_TIMEOUT_EN.
// Latency: first fifo_rxen 1 cycle after fs; fd rises n+2 cycles after fs with a never-empty FIFO.
// Backpressure: reads stall while fifo_empty; fd/ferr held until fs drops (four-phase fs/fd).
module fifo_frame_read #(
  parameter int DW    = 8,
  parameter int WORDS = 12,
  parameter int LW    = 12,
  parameter int TMO   = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                err,
  input  logic [LW-1:0]       len,
  input  logic [DW-1:0]       fifo_rxd,
  input  logic                fifo_empty,
  output logic                fifo_rxen,
  output logic [DW*WORDS-1:0] res,
  input  logic                fs,
  output logic                fd,
  output logic                ferr
);

  typedef enum logic [1:0] {IDLE, READ, DONE, FAIL} state_t;

  state_t        state, state_nxt;
  logic [LW-1:0] n, iss, rcv, len_clamp;
  logic          rvld, last, tmo_hit;

  assign len_clamp = (len > LW'(WORDS)) ? LW'(WORDS) : len;
  assign last      = rvld && (rcv == n - LW'(1));

`ifdef FIFO_READ_TIMEOUT_EN
  localparam int SW = $clog2(TMO + 1);
  logic [SW-1:0] stall;
  logic          stalling;

  // Only cycles that still owe a read count as stalls; waiting on the last return does not.
  assign stalling = (state == READ) && !fifo_rxen && (iss < n);
  assign tmo_hit  = stalling && (stall == SW'(TMO - 1));

  always_ff @(posedge clk) begin
    if (rst || state != READ || fifo_rxen) stall <= '0;
    else if (stalling)                      stall <= stall + SW'(1);
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fifo_rxen = 1'b0;
    fd        = 1'b0;
    ferr      = 1'b0;
    case (state)
      IDLE: begin
        if (fs) state_nxt = (len_clamp == '0) ? DONE : READ;
      end
      READ: begin
        fifo_rxen = !rst && !fifo_empty && (iss < n);
        // Abort outranks completion when both land in the same cycle.
        if (err || tmo_hit) state_nxt = FAIL;
        else if (last)      state_nxt = DONE;
      end
      DONE: begin
        fd = 1'b1;
        if (!fs) state_nxt = IDLE;
      end
      FAIL: begin
        fd   = 1'b1;
        ferr = 1'b1;
        if (!fs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n    <= '0;
      iss  <= '0;
      rcv  <= '0;
      rvld <= 1'b0;
      res  <= '0;
    end else begin
      case (state)
        IDLE: begin
          rvld <= 1'b0;
          if (fs) begin
            n   <= len_clamp;
            iss <= '0;
            rcv <= '0;
            res <= '0;
          end
        end
        READ: begin
          // A read issued on the abort cycle is dropped along with any already returning.
          rvld <= (err || tmo_hit) ? 1'b0 : fifo_rxen;
          if (fifo_rxen) iss <= iss + LW'(1);
          if (rvld && !err) begin
            rcv <= rcv + LW'(1);
            for (int k = 0; k < WORDS; k++)
              if (rcv == LW'(k)) res[(WORDS-1-k)*DW +: DW] <= fifo_rxd;
          end
        end
        default: rvld <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_frame_read.sv
// Randomised + directed bench for fifo_frame_read against a schedule-based frame model.
module tb_fifo_frame_read;

  localparam int DW    = 8;
  localparam int WORDS = 12;
  localparam int LW    = 12;
  localparam int TMO   = 255;
  localparam int RW    = DW * WORDS;
  localparam int MAXC  = 1200;

  logic          clk = 1'b0;
  logic          rst, err, fifo_empty, fifo_rxen, fs, fd, ferr;
  logic [LW-1:0] len;
  logic [DW-1:0] fifo_rxd;
  logic [RW-1:0] res;

  fifo_frame_read #(.DW(DW), .WORDS(WORDS), .LW(LW), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .err(err), .len(len), .fifo_rxd(fifo_rxd),
    .fifo_empty(fifo_empty), .fifo_rxen(fifo_rxen), .res(res),
    .fs(fs), .fd(fd), .ferr(ferr)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // FIFO with one-cycle read latency
  logic [DW-1:0] q[$];
  always @(posedge clk)
    if (fifo_rxen === 1'b1 && fifo_empty === 1'b0 && q.size() > 0) fifo_rxd <= q.pop_front();

  logic [DW-1:0] wtab[WORDS];
  bit            stall_tab[0:MAXC-1];

  bit            chk_on = 1'b0;
  logic          exp_rxen, exp_fd, exp_ferr;
  logic [RW-1:0] exp_res;
  int            cur_c, rx_cnt, fd_at;
  bit            fd_seen;
  logic [RW-1:0] res_fd;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("rxen", 128'(fifo_rxen), 128'(exp_rxen));
      chk("fd",   128'(fd),        128'(exp_fd));
      chk("ferr", 128'(ferr),      128'(exp_ferr));
      if (exp_fd) chk("res", 128'(res), 128'(exp_res));
      if (fifo_rxen === 1'b1) rx_cnt++;
      if (fd === 1'b1 && !fd_seen) begin
        fd_seen = 1'b1;
        fd_at   = cur_c;
        res_fd  = res;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; fs = 1'b0; err = 1'b0; fifo_empty = 1'b1; len = '0;
    exp_rxen = 1'b0; exp_fd = 1'b0; exp_ferr = 1'b0;
    step();
    chk_on = 1'b1;
    chk("rst_res",  128'(res), 128'd0);
    chk("rst_fd",   128'(fd), 128'd0);
    chk("rst_ferr", 128'(ferr), 128'd0);
    chk("rst_rxen", 128'(fifo_rxen), 128'd0);
    rst = 1'b0;
    step();
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      fs = 1'b0; err = 1'($urandom_range(0, 1)); len = LW'($urandom);
      fifo_empty = 1'($urandom_range(0, 1));
      exp_rxen = 1'b0; exp_fd = 1'b0; exp_ferr = 1'b0;
      step();
    end
  endtask

  // Cycle 0 is the cycle fs is first high. Reads land on the first n non-empty cycles from 1;
  // a read's data returns the cycle after it, and fd follows the last return by one cycle.
  task automatic run_frame(input int ln, input int err_at, input int drop_at, input int cap);
    int n, iss, last_rx, run, abort, done_fd, fd_cyc, fall, kept, last_c;
    bit fail;
    bit rxm[0:MAXC-1];
    logic [RW-1:0] er;
    for (int c = 0; c < MAXC; c++) rxm[c] = 1'b0;
    n = (ln > WORDS) ? WORDS : ln;
    iss = 0; last_rx = 0; run = 0; abort = -1;
    for (int c = 1; c < cap && iss < n; c++) begin
      if (!stall_tab[c]) begin
        rxm[c] = 1'b1; iss++; last_rx = c; run = 0;
      end else begin
        run++;
`ifdef FIFO_READ_TIMEOUT_EN
        if (run == TMO) begin abort = c; break; end
`endif
      end
    end
    done_fd = (n == 0) ? 1 : ((iss == n) ? last_rx + 2 : -1);
    if (err_at >= 1 && n > 0 && (done_fd < 0 || err_at <= done_fd - 1) &&
        (abort < 0 || err_at < abort))
      abort = err_at;
    fail = 1'b0; kept = n;
    if (abort >= 0) begin
      fd_cyc = abort + 1; fail = 1'b1; kept = 0;
      for (int c = 1; c < MAXC; c++) begin
        if (c > abort) rxm[c] = 1'b0;
        else if (rxm[c] && c <= abort - 2) kept++;
      end
    end else begin
      fd_cyc = done_fd;
    end
    er = '0;
    for (int k = 0; k < kept; k++) er = (er << DW) | RW'(wtab[k]);
    er = er << (DW * (WORDS - kept));
    fall   = (fd_cyc < 0) ? -1 : (((drop_at > fd_cyc) ? drop_at : fd_cyc) + 1);
    last_c = (fd_cyc < 0) ? cap - 1 : fall;

    for (int c = 0; c <= last_c; c++) begin
      if (c == 0) begin
        q.delete();
        for (int k = 0; k < WORDS; k++) q.push_back(wtab[k]);
        rx_cnt = 0; fd_seen = 1'b0; fd_at = -1; res_fd = '0;
      end
      cur_c      = c;
      fs         = (c < drop_at);
      len        = (c == 0) ? LW'(ln) : LW'($urandom);
      fifo_empty = (c == 0) ? 1'($urandom_range(0, 1)) : stall_tab[c];
      if (c == err_at)                 err = 1'b1;
      else if (fd_cyc >= 0 && c >= fd_cyc) err = 1'($urandom_range(0, 1));
      else                             err = 1'b0;
      exp_rxen = rxm[c];
      exp_fd   = (fd_cyc >= 0) && (c >= fd_cyc) && (c < fall);
      exp_ferr = exp_fd && fail;
      exp_res  = er;
      step();
    end
  endtask

  initial begin
    do_reset();

    // Full frame, FIFO never empty
    for (int k = 0; k < WORDS; k++) wtab[k] = DW'(k + 1);
    run_frame(12, -1, 20, MAXC);
    chk("f12_reads", 128'(rx_cnt), 128'd12);
    chk("f12_fd_at", 128'(fd_at), 128'd14);
    chk("f12_res", 128'(res_fd), 128'h0102030405060708090A0B0C);
    idle_cycles(1);

    // Short frame
    for (int k = 0; k < WORDS; k++) wtab[k] = DW'(8'hA1 + k);
    run_frame(4, -1, 10, MAXC);
    chk("f4_reads", 128'(rx_cnt), 128'd4);
    chk("f4_res", 128'(res_fd), 128'hA1A2A3A4_0000000000000000);

    // Over-length clamps, zero-length completes at once
    run_frame(20, -1, 16, MAXC);
    chk("f20_reads", 128'(rx_cnt), 128'd12);
    chk("f20_fd_at", 128'(fd_at), 128'd14);
    run_frame(0, -1, 3, MAXC);
    chk("f0_reads", 128'(rx_cnt), 128'd0);
    chk("f0_fd_at", 128'(fd_at), 128'd1);
    chk("f0_res", 128'(res_fd), 128'd0);

    // Three empty cycles after word 5
    for (int k = 0; k < WORDS; k++) wtab[k] = DW'(k + 1);
    stall_tab[6] = 1'b1; stall_tab[7] = 1'b1; stall_tab[8] = 1'b1;
    run_frame(12, -1, 18, MAXC);
    stall_tab[6] = 1'b0; stall_tab[7] = 1'b0; stall_tab[8] = 1'b0;
    chk("stall_fd_at", 128'(fd_at), 128'd17);
    chk("stall_res", 128'(res_fd), 128'h0102030405060708090A0B0C);

    // Error on the cycle word index 5 returns
    run_frame(12, 7, 12, MAXC);
    chk("err_fd_at", 128'(fd_at), 128'd8);
    chk("err_res", 128'(res_fd), 128'h0102030405_00000000000000);
    idle_cycles(2);

    // Reset in the middle of a read
    run_frame(12, -1, 1000, 5);
    chk("mid_reads", 128'(rx_cnt), 128'd4);
    do_reset();

    // FIFO runs dry after word 2
    for (int c = 3; c < MAXC; c++) stall_tab[c] = 1'b1;
`ifdef FIFO_READ_TIMEOUT_EN
    run_frame(12, -1, 300, 1100);
    chk("tmo_fd_at", 128'(fd_at), 128'd258);
    chk("tmo_res", 128'(res_fd), 128'h0102_00000000000000000000);
`else
    run_frame(12, -1, 2000, 1100);
    chk("hang_fd", 128'(fd_seen), 128'd0);
    chk("hang_reads", 128'(rx_cnt), 128'd2);
    do_reset();
`endif
    for (int c = 0; c < MAXC; c++) stall_tab[c] = 1'b0;

    // Randomised frames
    for (int f = 0; f < 40; f++) begin
      int ln, ea, da;
      for (int k = 0; k < WORDS; k++) wtab[k] = DW'($urandom);
      for (int c = 1; c < 200; c++) stall_tab[c] = ($urandom_range(0, 3) == 0);
      ln = int'($urandom_range(0, 20));
      ea = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 18)) : -1;
      da = int'($urandom_range(1, 25));
      run_frame(ln, ea, da, MAXC);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_frame_read.md
# fifo_frame_read

Parametrised frame reader that pulls a runtime-selected number of DW-bit words from a synchronous FIFO and assembles them into one wide result register. It sits behind the MAC receive FIFO and hands completed frames to downstream parsers over a four-phase fs/fd handshake. It generalises the fixed 12-byte reader with:
- configurable word width and frame depth;
- per-frame length;
- empty-aware stalling;
- explicit error/abort reporting.

## Interface
- DW, 8, FIFO word width in bits.
- WORDS, 12, maximum words per frame; res holds WORDS words.
- LW, 12, width of len input; must satisfy 2^LW > WORDS.
- TMO, 255, stall-timeout limit in cycles; used only when FIFO_READ_TIMEOUT_EN is defined.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- err  in  1  upstream frame error; aborts the active read.
- len  in  LW  words to read this frame; sampled on fs rise in IDLE.
- fifo_rxd  in  DW  FIFO read data, valid one cycle after fifo_rxen.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rxen  out  1  FIFO read enable; combinational from state and counters.
- res  out  DW*WORDS  assembled frame; word k at res[(WORDS-1-k)*DW +: DW], so word 0 is the MSBs.
- fs  in  1  frame start request, level.
- fd  out  1  frame done, level.
- ferr  out  1  frame ended in error; qualified by fd.

## Operation
States: IDLE, READ, DONE, FAIL.

IDLE:
- fd=0, ferr=0, fifo_rxen=0.
- On fs=1, capture n = min(len, WORDS), clear res to 0, clear the issue count (iss) and receive count (rcv).
- If n==0, go to DONE; otherwise go to READ.

READ:
- fifo_rxen = !fifo_empty && iss<n.
- Each cycle fifo_rxen=1 increments iss.
- A one-cycle delayed copy of fifo_rxen (rvld) marks returning data. On rvld, write fifo_rxd to word rcv and increment rcv.
- When rvld and rcv==n-1, go to DONE.
- Words rcv..WORDS-1 remain 0.

DONE:
- fd=1, ferr=0, res held.
- On fs=0, go to IDLE.

FAIL:
- fd=1, ferr=1, res holds the words received so far.
- On fs=0, go to IDLE.

Error handling:
- err=1 in READ moves to FAIL next cycle and takes priority over completion in the same cycle.
- Any read already in flight is discarded; rvld is cleared on entry to FAIL.
- err is ignored in IDLE, DONE and FAIL.

Other rules:
- fs dropping during READ has no effect; the frame completes and fd then drops on the next cycle because fs is already 0.
- iss and rcv are LW bits wide, and iss never exceeds n, so no wrap is possible.
- Unused state encodings return to IDLE.

## Timing
- Reset (synchronous): state=IDLE, res=0, fd=0, ferr=0, iss=rcv=0, rvld=0. fifo_rxen=0 during and after reset.
- Latency from fs sampled high to first fifo_rxen is 1 cycle (given FIFO not empty).
- With the FIFO never empty, fd rises n+2 cycles after the cycle in which fs is sampled.
- Throughput is one word per cycle; an empty cycle inserts exactly one bubble.
- fd falls 1 cycle after fs is sampled low. The next frame may start on the cycle after IDLE is re-entered.
- Asserting rst mid-frame clears everything on the next edge. FIFO contents are not flushed; that is the caller's responsibility.

## Configuration
- FIFO_READ_TIMEOUT_EN defined:
  - A stall counter increments each READ cycle with fifo_rxen=0 and iss<n.
  - The counter clears on any fifo_rxen.
  - When the counter reaches TMO, the block goes to FAIL with ferr=1.
- Undefined: no counter; READ waits indefinitely on an empty FIFO.

## Test plan
- DW=8, WORDS=12, len=12, FIFO holds 0x01..0x0C and is never empty -> 12 fifo_rxen pulses; fd rises 14 cycles after fs; res=0x0102030405060708090A0B0C; ferr=0.
- len=4, data 0xA1..0xA4 -> exactly 4 reads; res=0xA1A2A3A4 followed by 16 zero hex digits.
- len=20 (greater than WORDS) -> clamped to 12 reads; len=0 -> fd 1 cycle after fs with res=0 and no reads.
- FIFO empty for 3 cycles after word 5 -> fifo_rxen low for exactly those 3 cycles; final res identical to the no-stall case; fd delayed by 3 cycles.
- err pulsed on the cycle word 6 returns -> FAIL; fd=1, ferr=1; res holds words 0-4 only (word 5 discarded); fd clears 1 cycle after fs=0; rst mid-READ -> all outputs 0 next cycle.
- FIFO_READ_TIMEOUT_EN, TMO=255, FIFO empty after word 2 -> FAIL with ferr=1 exactly 255 stall cycles later; without the macro -> still in READ after 1000 cycles.
